// File: rtl/input_conditioner.sv
// Synchronizes and debounces raw board inputs, turns a step press into a
// single-cycle pulse and derives the counter FSM advance enable.

module input_conditioner_sync #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] sync_o
);

   logic [W-1:0] s1_q, s1_d;
   logic [W-1:0] s2_q, s2_d;

   always_comb begin
      s1_d = raw_i;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign sync_o = s2_q;

endmodule

module input_conditioner_debounce #(
   parameter int             W       = 1,
   parameter int             D       = 4,
   parameter int             CNT_W   = 3,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] sync_i,
   output logic [W-1:0] deb_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

   logic [W-1:0]     deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any mismatch keeps counting, even if the mismatching value moves;
   // the value present on the terminal cycle is the one loaded.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync_i != deb_q) begin
         if (cnt_q == LAST) begin
            deb_d = sync_i;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= RST_VAL;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign deb_o = deb_q;

endmodule

module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clk_1hz,
   input  logic       reset_button,
   input  logic       mode_switch_raw,
   input  logic [1:0] fsm_input_x_raw,
   input  logic       step_button_raw,
   output logic       mode_out,
   output logic [1:0] fsm_input_x,
   output logic       step_pulse,
   output logic       advance_en
);

   logic       rst_n;
   logic       mode_sync;
   logic [1:0] x_sync;
   logic       step_sync;
   logic       mode_deb;
   logic [1:0] x_deb;
   logic       step_deb;
   logic       mode_chg;

   logic step_prev_q, step_prev_d;
   logic mode_prev_q, mode_prev_d;
   logic step_pulse_q, step_pulse_d;
   logic advance_en_q, advance_en_d;

   assign rst_n = reset_button;

   input_conditioner_sync #(
      .W       (1),
      .RST_VAL (1'b1)
   ) u_sync_mode (
      .clk    (clk_1hz),
      .rst_n  (rst_n),
      .raw_i  (mode_switch_raw),
      .sync_o (mode_sync)
   );

   input_conditioner_sync #(
      .W       (2),
      .RST_VAL (2'b00)
   ) u_sync_x (
      .clk    (clk_1hz),
      .rst_n  (rst_n),
      .raw_i  (fsm_input_x_raw),
      .sync_o (x_sync)
   );

   input_conditioner_sync #(
      .W       (1),
      .RST_VAL (1'b1)
   ) u_sync_step (
      .clk    (clk_1hz),
      .rst_n  (rst_n),
      .raw_i  (step_button_raw),
      .sync_o (step_sync)
   );

   input_conditioner_debounce #(
      .W       (1),
      .D       (DEBOUNCE_CYCLES),
      .CNT_W   (CNT_W),
      .RST_VAL (1'b1)
   ) u_deb_mode (
      .clk    (clk_1hz),
      .rst_n  (rst_n),
      .sync_i (mode_sync),
      .deb_o  (mode_deb)
   );

   input_conditioner_debounce #(
      .W       (2),
      .D       (DEBOUNCE_CYCLES),
      .CNT_W   (CNT_W),
      .RST_VAL (2'b00)
   ) u_deb_x (
      .clk    (clk_1hz),
      .rst_n  (rst_n),
      .sync_i (x_sync),
      .deb_o  (x_deb)
   );

   input_conditioner_debounce #(
      .W       (1),
      .D       (DEBOUNCE_CYCLES),
      .CNT_W   (CNT_W),
      .RST_VAL (1'b1)
   ) u_deb_step (
      .clk    (clk_1hz),
      .rst_n  (rst_n),
      .sync_i (step_sync),
      .deb_o  (step_deb)
   );

   // A press landing on the mode-change cycle is dropped, not deferred.
   always_comb begin
      step_prev_d  = step_deb;
      mode_prev_d  = mode_deb;
      step_pulse_d = step_prev_q & ~step_deb;
      mode_chg     = mode_prev_q ^ mode_deb;
      if (mode_chg) begin
         advance_en_d = 1'b0;
      end else if (mode_deb) begin
         advance_en_d = 1'b1;
      end else begin
         advance_en_d = step_pulse_d;
      end
   end

   always_ff @(posedge clk_1hz or negedge rst_n) begin
      if (!rst_n) begin
         step_prev_q  <= 1'b1;
         mode_prev_q  <= 1'b1;
         step_pulse_q <= 1'b0;
         advance_en_q <= 1'b0;
      end else begin
         step_prev_q  <= step_prev_d;
         mode_prev_q  <= mode_prev_d;
         step_pulse_q <= step_pulse_d;
         advance_en_q <= advance_en_d;
      end
   end

   assign mode_out    = mode_deb;
   assign fsm_input_x = x_deb;
   assign step_pulse  = step_pulse_q;
   assign advance_en  = advance_en_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected output trace is
// queued per cycle as stimulus is driven and popped after each edge.

module tb_input_conditioner;

   localparam int D = 4;

   typedef struct packed {
      logic       m;
      logic [1:0] x;
      logic       p;
      logic       a;
   } exp_t;

   logic       clk;
   logic       reset_button;
   logic       mode_raw;
   logic [1:0] x_raw;
   logic       step_raw;
   logic       mode_out;
   logic [1:0] fsm_input_x;
   logic       step_pulse;
   logic       advance_en;

   exp_t       sb_q[$];
   int         n_checks;
   int         n_fail;
   logic       cur_mode;
   logic [1:0] cur_x;

   input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk_1hz         (clk),
      .reset_button    (reset_button),
      .mode_switch_raw (mode_raw),
      .fsm_input_x_raw (x_raw),
      .step_button_raw (step_raw),
      .mode_out        (mode_out),
      .fsm_input_x     (fsm_input_x),
      .step_pulse      (step_pulse),
      .advance_en      (advance_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h exp=%0h",
                  tag, $time, obs, exp);
      end
   endtask

   task automatic push(input logic m, input logic [1:0] x,
                       input logic p, input logic a);
      exp_t e;
      e.m = m;
      e.x = x;
      e.p = p;
      e.a = a;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 8'd1, 8'd0);
      end else begin
         e = sb_q.pop_front();
         chk("mode_out", mode_out, e.m);
         chk("fsm_input_x", fsm_input_x, e.x);
         chk("step_pulse", step_pulse, e.p);
         chk("advance_en", advance_en, e.a);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mode"}, mode_out, 8'd1);
      chk({tag, "_x"}, fsm_input_x, 8'd0);
      chk({tag, "_pulse"}, step_pulse, 8'd0);
      chk({tag, "_adv"}, advance_en, 8'd0);
   endtask

   task automatic run_const(input int n);
      for (int k = 0; k < n; k++) push(cur_mode, cur_x, 1'b0, cur_mode);
      repeat (n) tick();
   endtask

   task automatic x_change(input logic [1:0] nx);
      @(negedge clk);
      x_raw = nx;
      for (int k = 0; k < 10; k++)
         push(cur_mode, (k >= D + 1) ? nx : cur_x, 1'b0, cur_mode);
      repeat (10) tick();
      cur_x = nx;
   endtask

   // Pulse expected at E0+D+2 only when the press lasts >= D cycles.
   task automatic press(input int hold, input int rel);
      logic p;
      @(negedge clk);
      step_raw = 1'b0;
      for (int k = 0; k < hold + rel; k++) begin
         p = (hold >= D) && (k == D + 2);
         push(cur_mode, cur_x, p, cur_mode | p);
      end
      repeat (hold) tick();
      @(negedge clk);
      step_raw = 1'b1;
      repeat (rel) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      reset_button = 1'b1;
      mode_raw     = 1'b1;
      x_raw        = 2'b01;
      step_raw     = 1'b1;
      cur_mode     = 1'b1;
      cur_x        = 2'b00;

      // reset held with mode=1, x=01 on the raw pins
      #2 reset_button = 1'b0;
      #1 chk_reset_vals("rst_async");
      repeat (10) @(posedge clk);
      #1 chk_reset_vals("rst_held");
      @(negedge clk);
      reset_button = 1'b1;
      for (int k = 0; k < 10; k++)
         push(1'b1, (k >= D + 1) ? 2'b01 : 2'b00, 1'b0, 1'b1);
      repeat (10) tick();
      cur_x = 2'b01;

      // debounce latency and vector changes
      x_change(2'b10);
      x_change(2'b00);
      x_change(2'b01);
      x_change(2'b00);

      // 3-cycle glitch on x
      @(negedge clk);
      x_raw = 2'b11;
      run_const(3);
      @(negedge clk);
      x_raw = 2'b00;
      run_const(8);

      // auto -> manual with suppression cycle
      @(negedge clk);
      mode_raw = 1'b0;
      for (int k = 0; k < 10; k++)
         push(k < D + 1, cur_x, 1'b0, k <= D + 1);
      repeat (10) tick();
      cur_mode = 1'b0;

      // manual step: blip, long presses, minimum press
      press(3, 8);
      press(20, 10);
      press(20, 10);
      press(D, 8);

      // press coinciding with manual -> auto suppression
      @(negedge clk);
      step_raw = 1'b0;
      mode_raw = 1'b1;
      for (int k = 0; k < 12; k++)
         push(k >= D + 1, cur_x, k == D + 2, k >= D + 3);
      repeat (12) tick();
      cur_mode = 1'b1;
      @(negedge clk);
      step_raw = 1'b1;
      run_const(8);

      // reset at count 3 of a pending x change, mid step press
      x_change(2'b01);
      @(negedge clk);
      x_raw    = 2'b10;
      step_raw = 1'b0;
      for (int k = 0; k < 5; k++) push(1'b1, 2'b01, 1'b0, 1'b1);
      repeat (5) tick();
      #2 reset_button = 1'b0;
      #1 chk_reset_vals("rst_mid");
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("rst_mid_held");
      @(negedge clk);
      reset_button = 1'b1;
      cur_x = 2'b00;
      for (int k = 0; k < 12; k++)
         push(1'b1, (k >= D + 1) ? 2'b10 : 2'b00, k == D + 2, 1'b1);
      repeat (12) tick();
      cur_x = 2'b10;
      @(negedge clk);
      step_raw = 1'b1;
      run_const(8);

      chk("sb_empty", 8'(sb_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage feeding the counter FSM in `top_level`. It synchronizes and debounces the raw board inputs (mode switch, 2-bit FSM command, active-low step button), and converts a step press into a single-cycle pulse. It produces `advance_en`, the per-cycle enable that tells the counter FSM when to take a step: every cycle in auto mode, or once per debounced press in manual mode.

## Interface

- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a debounced output changes (≥1).
- `CNT_W`, 3: stability-counter width; must hold `DEBOUNCE_CYCLES`.

Ports:
- `clk_1hz` in 1: the single system clock; all logic is on its rising edge.
- `reset_button` in 1: asynchronous, active-low reset.
- `mode_switch_raw` in 1: async raw mode switch; 1 = auto, 0 = manual step.
- `fsm_input_x_raw` in 2: async raw FSM command. 00 hold, 01 up, 10 down, 11 soft reset.
- `step_button_raw` in 1: async raw step button, active-low (idle 1).
- `mode_out` out 1: debounced mode.
- `fsm_input_x` out 2: debounced command.
- `step_pulse` out 1: one-cycle pulse per debounced press.
- `advance_en` out 1: step enable to the counter FSM.

## Operation

- Synchronizers: 2-flop chain on each of the 4 raw bits.
  - Reset values: mode 1, x 00, step 1.
- Debouncers: three independent instances (mode, x as a 2-bit vector, step), each holding a debounced value and a stability counter.
  - Synchronized value equals the debounced value: the counter clears to 0.
  - Synchronized value differs: the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced value loads the synchronized value and the counter clears.
  - x is compared as a whole vector. A mismatch that changes to a different mismatching value (01→10 mid-count) keeps counting. The value loaded is the one present on the terminal cycle.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the output.
- Step edge detector: a registered previous debounced step level.
  - `step_pulse` = 1 for exactly one cycle after the debounced step level goes 1→0.
  - Release (0→1) produces nothing.
  - A held button produces one pulse only.
- `advance_en` (registered) is computed in this order:
  1. Cycle after a debounced mode change: 0. This is the suppression cycle.
  2. Otherwise, auto mode (`mode_out`=1): 1.
  3. Otherwise, manual mode: equals `step_pulse`.
- Mode change vs. press: a press whose pulse coincides with the suppression cycle is discarded, not deferred.
- Outputs are registered. `fsm_input_x` and `mode_out` hold between updates.
- Reset values (asynchronous, while `reset_button`=0):
  - `mode_out`=1, `fsm_input_x`=00, `step_pulse`=0, `advance_en`=0.
  - Internal debounced step level = 1; all counters = 0.
- Reset asserted mid-debounce: counters and in-flight pulses are discarded immediately.
- After reset release, the first `advance_en`=1 in auto mode appears after the first rising edge.

## Timing

- Let E0 be the first rising edge that samples a new raw level (raw stable from E0 onward).
  - Synchronized value is visible after E0+1.
  - The counter increments at edges E0+2 … E0+1+D, where D = `DEBOUNCE_CYCLES`.
  - The debounced output changes after edge E0+1+D. With D=4: E0+5.
- `step_pulse` and manual-mode `advance_en` assert after edge E0+2+D (E0+6 for D=4), for one cycle.
- Mode change: `mode_out` updates after E0+1+D. `advance_en` is 0 for the cycle after E0+2+D, then follows the new mode.
- Minimum press-to-press spacing for two distinct pulses: press ≥ D cycles, release ≥ D cycles.
- No combinational path from any input to any output.

## Test plan

- Reset: hold `reset_button`=0 for 10 cycles with mode raw=1 and x raw=01.
  - During reset: `mode_out`=1, `fsm_input_x`=00, `step_pulse`=0, `advance_en`=0.
  - After release: `advance_en`=1 from the first edge; x=01 appears after E0+5.
- Debounce latency: x raw 00→01 at E0 with D=4.
  - `fsm_input_x`=00 through edge E0+4 and 01 after E0+5.
  - Then 01→10 (soft change): same latency, no intermediate 11.
- Glitch rejection: x raw pulses 00→11 for 3 cycles, then back to 00.
  - `fsm_input_x` stays 00.
  - The step raw 3-cycle low blip gives no `step_pulse`.
- Manual step: mode raw=0 (debounced), then step raw held low for 20 cycles.
  - Exactly one `step_pulse`/`advance_en` cycle, at E0+6.
  - Release, then press again: a second single pulse.
- Mode switch: in auto mode, mode raw 1→0.
  - `advance_en`=1 until the mode update, then 0 for the suppression cycle, then 0 (manual idle).
  - Switching back 0→1 gives one 0 cycle, then continuous 1.
- Reset mid-operation: assert reset at count 3 of a pending x change and mid-step-press.
  - Outputs go to reset values asynchronously, with no pulse.
  - After release, the still-held raw values re-debounce with full latency.
